// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped table of {valid, tag, target, ctr}.
// Fetch looks up pc_f combinationally (no bypass of same-cycle updates);
// execute writes resolved outcomes back at posedge clk.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   pc_f, lookup_valid_f   fetch lookup request
//   pred_hit_f/_taken_f/_target_f   combinational prediction
//   update_*_e             resolved branch/jump from execute
//   lookup_count, mispredict_count  saturating performance counters
module branch_predictor #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned IDX_W  = 4,
  parameter int unsigned TAG_W  = 8,
  parameter int unsigned CTR_W  = 2,
  parameter int unsigned PERF_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   pc_f,
  input  logic              lookup_valid_f,
  output logic              pred_hit_f,
  output logic              pred_taken_f,
  output logic [XLEN-1:0]   pred_target_f,
  input  logic              update_valid_e,
  input  logic [XLEN-1:0]   update_pc_e,
  input  logic              update_taken_e,
  input  logic              update_jump_e,
  input  logic [XLEN-1:0]   update_target_e,
  input  logic              update_pred_taken_e,
  output logic [PERF_W-1:0] lookup_count,
  output logic [PERF_W-1:0] mispredict_count
);

  localparam int unsigned ENTRIES = 2 ** IDX_W;
  localparam int unsigned TAG_LO  = IDX_W + 2;
  localparam int unsigned TAG_HI  = IDX_W + 1 + TAG_W;

  localparam logic [CTR_W-1:0]  CTR_MAX  = '1;
  localparam logic [CTR_W-1:0]  CTR_WT   = CTR_W'(1) << (CTR_W - 1);
  localparam logic [CTR_W-1:0]  CTR_WNT  = CTR_WT - CTR_W'(1);
  localparam logic [PERF_W-1:0] PERF_MAX = '1;

  // Table storage
  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [XLEN-1:0]   target_q [ENTRIES];
  logic [CTR_W-1:0]  ctr_q    [ENTRIES];

  logic [PERF_W-1:0] lk_cnt_q, lk_cnt_d;
  logic [PERF_W-1:0] mp_cnt_q, mp_cnt_d;

  logic [IDX_W-1:0]  lk_idx, up_idx;
  logic [TAG_W-1:0]  lk_tag, up_tag;
  logic              up_hit;

  logic              wr_en;
  logic              wr_valid;
  logic [TAG_W-1:0]  wr_tag;
  logic [XLEN-1:0]   wr_target;
  logic [CTR_W-1:0]  wr_ctr;

  assign lk_idx = pc_f[IDX_W+1:2];
  assign lk_tag = pc_f[TAG_HI:TAG_LO];
  assign up_idx = update_pc_e[IDX_W+1:2];
  assign up_tag = update_pc_e[TAG_HI:TAG_LO];

  // Lookup: pre-update contents, forced quiet while reset is asserted
  always_comb begin
    pred_hit_f    = !rst && valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    pred_taken_f  = pred_hit_f && ctr_q[lk_idx][CTR_W-1];
    pred_target_f = pred_hit_f ? target_q[lk_idx] : '0;
  end

  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  // Next contents of the single entry touched by an update
  always_comb begin
    wr_en     = 1'b0;
    wr_valid  = valid_q[up_idx];
    wr_tag    = tag_q[up_idx];
    wr_target = target_q[up_idx];
    wr_ctr    = ctr_q[up_idx];
    if (update_valid_e) begin
      if (up_hit) begin
        wr_en = 1'b1;
        if (update_jump_e) begin
          wr_ctr    = CTR_MAX;
          wr_target = update_target_e;
        end else if (update_taken_e) begin
          wr_ctr    = (ctr_q[up_idx] == CTR_MAX) ? CTR_MAX : ctr_q[up_idx] + CTR_W'(1);
          wr_target = update_target_e;
        end else begin
          wr_ctr    = (ctr_q[up_idx] == '0) ? '0 : ctr_q[up_idx] - CTR_W'(1);
        end
      end else if (update_taken_e) begin
        wr_en     = 1'b1;
        wr_valid  = 1'b1;
        wr_tag    = up_tag;
        wr_target = update_target_e;
        wr_ctr    = update_jump_e ? CTR_MAX : CTR_WT;
      end
    end
  end

  // Saturating performance counters
  always_comb begin
    lk_cnt_d = lk_cnt_q;
    mp_cnt_d = mp_cnt_q;
    if (lookup_valid_f && (lk_cnt_q != PERF_MAX))
      lk_cnt_d = lk_cnt_q + PERF_W'(1);
    if (update_valid_e && (update_pred_taken_e != update_taken_e) && (mp_cnt_q != PERF_MAX))
      mp_cnt_d = mp_cnt_q + PERF_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= '{default: 1'b0};
      tag_q    <= '{default: '0};
      target_q <= '{default: '0};
      ctr_q    <= '{default: CTR_WNT};
      lk_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else begin
      if (wr_en) begin
        valid_q[up_idx]  <= wr_valid;
        tag_q[up_idx]    <= wr_tag;
        target_q[up_idx] <= wr_target;
        ctr_q[up_idx]    <= wr_ctr;
      end
      lk_cnt_q <= lk_cnt_d;
      mp_cnt_q <= mp_cnt_d;
    end
  end

  assign lookup_count     = lk_cnt_q;
  assign mispredict_count = mp_cnt_q;

  // PC bits that take no part in index or tag
  logic unused_pc_bits;
  generate
    if (TAG_HI + 1 < XLEN) begin : g_hi_unused
      assign unused_pc_bits = ^{pc_f[1:0], update_pc_e[1:0],
                                pc_f[XLEN-1:TAG_HI+1], update_pc_e[XLEN-1:TAG_HI+1]};
    end else begin : g_no_hi
      assign unused_pc_bits = ^{pc_f[1:0], update_pc_e[1:0]};
    end
  endgenerate

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor (PERF_W=4 so saturation is reachable).
module tb_branch_predictor;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned PERF_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [XLEN-1:0]   pc_f;
  logic              lookup_valid_f;
  logic              pred_hit_f, pred_taken_f;
  logic [XLEN-1:0]   pred_target_f;
  logic              update_valid_e;
  logic [XLEN-1:0]   update_pc_e;
  logic              update_taken_e, update_jump_e, update_pred_taken_e;
  logic [XLEN-1:0]   update_target_e;
  logic [PERF_W-1:0] lookup_count, mispredict_count;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       name;
    logic        hit;
    logic        taken;
    logic [31:0] tgt;
    int          lc;
    int          mc;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  branch_predictor #(.XLEN(XLEN), .IDX_W(4), .TAG_W(8), .CTR_W(2), .PERF_W(PERF_W)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .pc_f                (pc_f),
    .lookup_valid_f      (lookup_valid_f),
    .pred_hit_f          (pred_hit_f),
    .pred_taken_f        (pred_taken_f),
    .pred_target_f       (pred_target_f),
    .update_valid_e      (update_valid_e),
    .update_pc_e         (update_pc_e),
    .update_taken_e      (update_taken_e),
    .update_jump_e       (update_jump_e),
    .update_target_e     (update_target_e),
    .update_pred_taken_e (update_pred_taken_e),
    .lookup_count        (lookup_count),
    .mispredict_count    (mispredict_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: each presented lookup pops one expectation
  always @(negedge clk) begin
    if (lookup_valid_f === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_empty: lookup pc=0x%0h with no expectation", pc_f);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk({e.name, ".hit"},    32'(pred_hit_f),   32'(e.hit));
        chk({e.name, ".taken"},  32'(pred_taken_f), 32'(e.taken));
        chk({e.name, ".target"}, pred_target_f,     e.tgt);
        if (e.lc >= 0) chk({e.name, ".lookup_count"},     32'(lookup_count),     32'(e.lc));
        if (e.mc >= 0) chk({e.name, ".mispredict_count"}, 32'(mispredict_count), 32'(e.mc));
      end
    end
  end

  task automatic idle();
    lookup_valid_f = 1'b0; pc_f = '0;
    update_valid_e = 1'b0; update_pc_e = '0; update_taken_e = 1'b0;
    update_jump_e = 1'b0; update_target_e = '0; update_pred_taken_e = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic lookup(input logic [31:0] pc, input string name, input logic hit,
                        input logic taken, input logic [31:0] tgt, input int lc, input int mc);
    exp_t e;
    e.name = name; e.hit = hit; e.taken = taken; e.tgt = tgt; e.lc = lc; e.mc = mc;
    exp_q.push_back(e);
    lookup_valid_f = 1'b1;
    pc_f           = pc;
  endtask

  task automatic update(input logic [31:0] pc, input logic taken, input logic jump,
                        input logic [31:0] tgt, input logic pred);
    update_valid_e      = 1'b1;
    update_pc_e         = pc;
    update_taken_e      = taken;
    update_jump_e       = jump;
    update_target_e     = tgt;
    update_pred_taken_e = pred;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    // Cold table
    lookup(32'h40, "cold_0x40", 0, 0, 32'h0, 0, 0); tick();
    // Allocate 0x40 weakly taken, counted as mispredict
    update(32'h40, 1, 0, 32'h100, 0); tick();
    lookup(32'h40, "alloc_0x40", 1, 1, 32'h100, 1, 1); tick();
    // Decrement to 0 and saturate; lookup in same cycle sees pre-update ctr=0
    update(32'h40, 0, 0, 32'h0, 1); tick();
    update(32'h40, 0, 0, 32'h0, 0); tick();
    update(32'h40, 0, 0, 32'h0, 0);
    lookup(32'h40, "ctr_floor", 1, 0, 32'h100, 2, 2); tick();
    update(32'h40, 1, 0, 32'h100, 0); tick();
    lookup(32'h40, "ctr_one", 1, 0, 32'h100, 3, 3); tick();
    // Alias at index 0 with tag 2 evicts 0x40
    update(32'h80, 1, 0, 32'h300, 0); tick();
    lookup(32'h40, "evicted_0x40", 0, 0, 32'h0, 4, 4); tick();
    lookup(32'h80, "alias_0x80", 1, 1, 32'h300, 5, 4); tick();
    // JAL allocation; same-cycle lookup has no bypass
    update(32'h44, 1, 1, 32'h200, 0);
    lookup(32'h44, "jal_no_bypass", 0, 0, 32'h0, 6, 4); tick();
    lookup(32'h44, "jal_ctr3", 1, 1, 32'h200, 7, 5); tick();
    update(32'h44, 0, 0, 32'h0, 1); tick();
    lookup(32'h44, "jal_ctr2", 1, 1, 32'h200, 8, 6); tick();
    // Not-taken miss allocates nothing
    update(32'h48, 0, 0, 32'h0, 0); tick();
    lookup(32'h48, "nt_miss", 0, 0, 32'h0, 9, 6); tick();
    // Reset mid-operation with update pending: outputs quiet, update dropped
    rst = 1'b1;
    update(32'h48, 1, 0, 32'h500, 0);
    lookup(32'h44, "in_reset", 0, 0, 32'h0, 10, 6); tick();
    rst = 1'b0;
    lookup(32'h48, "after_reset_0x48", 0, 0, 32'h0, 0, 0); tick();
    lookup(32'h44, "after_reset_0x44", 0, 0, 32'h0, 1, 0); tick();
    // Lookup counter saturates at 15
    for (int i = 0; i < 20; i++) begin
      lookup(32'h40, "lk_sat", 0, 0, 32'h0, (2 + i > 15) ? 15 : 2 + i, 0); tick();
    end
    // Mispredict counter saturates at 15
    for (int i = 0; i < 20; i++) begin
      update(32'h48, 0, 0, 32'h0, 1); tick();
    end
    lookup(32'h48, "mp_sat", 0, 0, 32'h0, 15, 15); tick();

    tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised dynamic branch predictor for the pipelined RV32I core; replaces static predict-not-taken in the fetch stage.
- Fetch issues a combinational lookup on pc_f. Execute writes back resolved branch/jump outcomes.
- Storage: direct-mapped table of {valid, tag, target, saturating counter} entries.
- Also keeps a saturating count of lookups and mispredictions for performance evaluation.

Parameters:
- XLEN, 32, address/data width.
- IDX_W, 4, log2 of entry count (ENTRIES = 2**IDX_W).
- TAG_W, 8, stored tag bits; constraint IDX_W+2+TAG_W <= XLEN.
- CTR_W, 2, saturating direction counter width, >= 1.
- PERF_W, 16, performance counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- pc_f  in  XLEN  fetch-stage PC to predict.
- lookup_valid_f  in  1  fetch issued a lookup this cycle (low when stall_f).
- pred_hit_f  out  1  valid entry with matching tag.
- pred_taken_f  out  1  predict taken.
- pred_target_f  out  XLEN  predicted target; 0 when not hit.
- update_valid_e  in  1  resolved branch/jump in EX this cycle (low when flushed bubble).
- update_pc_e  in  XLEN  PC of resolved instruction.
- update_taken_e  in  1  actual direction (jumps always 1).
- update_jump_e  in  1  instruction is JAL.
- update_target_e  in  XLEN  actual target (pc_target_e).
- update_pred_taken_e  in  1  prediction originally made for this instruction, carried down the pipe.
- lookup_count  out  PERF_W  saturating count of accepted lookups.
- mispredict_count  out  PERF_W  saturating count of mispredicted updates.

Behaviour:
- Index = pc[IDX_W+1:2]; tag = pc[IDX_W+1+TAG_W:IDX_W+2]. pc[1:0] ignored.
- Lookup (combinational, zero latency):
  - pred_hit_f = valid[idx] & (tag[idx] == tag(pc_f)).
  - pred_taken_f = pred_hit_f & ctr[idx][CTR_W-1].
  - pred_target_f = pred_hit_f ? target[idx] : 0.
- Update is registered at posedge clk when update_valid_e is high.
  - Hit and update_jump_e: ctr = max, target written.
  - Hit, taken: ctr increments and saturates at 2**CTR_W-1; target written.
  - Hit, not taken: ctr decrements and saturates at 0; target unchanged.
  - Miss and taken: allocate, overwriting any existing entry. Set valid=1 and write tag and target. ctr = max if jump, else 2**(CTR_W-1) (weakly taken).
  - Miss and not taken: no change.
- Simultaneous lookup and update to the same index: the lookup returns pre-update contents; there is no bypass. The new contents are visible from the next cycle.
- Mispredict definition for counting: update_pred_taken_e != update_taken_e. A taken branch predicted taken but with a stale target is not counted; the core detects that separately.
- Performance counters:
  - lookup_count increments when lookup_valid_f is high.
  - mispredict_count increments on a mispredicted update.
  - Both hold at 2**PERF_W-1 and never wrap.
- Reset (synchronous, may occur mid-operation; takes priority over update):
  - All valid bits = 0; all ctr = 2**(CTR_W-1)-1 (weakly not-taken); tags and targets = 0.
  - Both perf counters = 0.
  - In the reset cycle and the cycle after it: pred_hit_f = 0, pred_taken_f = 0, pred_target_f = 0.
  - An update presented during reset is dropped.
- CTR_W = 1: counter is a last-outcome bit. Allocation value = 1, reset value = 0.
- No internal state machine beyond per-entry counters. Table storage is flops; no SRAM read latency.

Test Plan:
- Reset, then lookup pc_f=0x40 -> pred_hit_f=0, pred_taken_f=0, pred_target_f=0; lookup_count=1 after one cycle with lookup_valid_f=1.
- Update pc=0x40, taken, target=0x100, pred_taken=0; then lookup 0x40 -> hit=1, taken=1 (ctr=2), target=0x100; mispredict_count=1.
- Two not-taken updates on 0x40 (ctr 2->1->0), then a third -> ctr stays 0, taken=0, hit=1. One taken update -> ctr=1, still predicts not-taken.
- Alias: update pc=0x80 taken (same index 0, tag 2) after 0x40 entry -> lookup 0x40 hit=0; lookup 0x80 hit=1.
- JAL update pc=0x44, target=0x200, jump=1 -> ctr=3; then one not-taken update -> ctr=2, still predicts taken. Same-cycle lookup of 0x44 during the first update -> hit=0.
- Not-taken miss update pc=0x48 -> lookup 0x48 hit=0. Assert rst while update_valid_e=1 -> entry not written, counters 0. With PERF_W=4, 20 lookups -> lookup_count=15.
